// File: rtl/tinyriscv_soc.sv
// tinyriscv_soc: single-cycle RV32I core with a writable instruction/data ROM
// at 0x0000_0000 and a data RAM at 0x1000_0000.

// 32 x 32-bit register file: two asynchronous read ports, one synchronous write port.
module tinyriscv_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    // Write port; x0 is never written so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
endmodule

// Program ROM: combinational instruction and data reads, byte-enabled store port
// so that initialised data sections living in the image can be updated.
module tinyriscv_rom #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic [29:0] inst_word,
    output logic [31:0] inst,
    input  logic [29:0] data_word,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   _rom [0:DEPTH-1];
    logic [AW-1:0] inst_idx;
    logic [AW-1:0] data_idx;

    assign inst_idx = AW'(inst_word % 30'(DEPTH));
    assign data_idx = AW'(data_word % 30'(DEPTH));
    assign inst     = _rom[inst_idx];
    assign rdata    = _rom[data_idx];

    // Byte-lane store; lanes whose strobe is low keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                _rom[data_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// Data RAM: combinational read, byte-enabled synchronous write, no reset.
module tinyriscv_ram #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic [29:0] data_word,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [0:DEPTH-1];
    logic [AW-1:0] data_idx;

    assign data_idx = AW'(data_word % 30'(DEPTH));
    assign rdata    = mem[data_idx];

    // Byte-lane store; lanes whose strobe is low keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                mem[data_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// Single-cycle RV32I core: fetch, decode, execute, memory and writeback in one clock.
module tinyriscv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    output logic [29:0] inst_word,
    input  logic [31:0] inst,
    output logic [29:0] mem_word,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct7_5;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        branch_taken;
    logic [31:0] mem_addr;
    logic [1:0]  lane;
    logic [31:0] rdata_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [3:0]  store_strb;
    logic [31:0] store_data;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct7_5 = inst[30];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    tinyriscv_regs u_regs_2023211063 (
        .clk    (clk),
        .rst    (rst),
        .we     (rd_we && !hold),
        .waddr  (rd),
        .wdata  (rd_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    assign inst_word = pc[31:2];

    assign mem_addr      = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_word      = mem_addr[31:2];
    assign lane          = mem_addr[1:0];
    assign rdata_shifted = mem_rdata >> {lane, 3'b000};
    assign load_byte     = rdata_shifted[7:0];
    assign load_half     = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    assign mem_wdata = store_data;
    assign mem_wstrb = (hold || !rst) ? 4'b0000 : store_strb;

    assign alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;

    // Shared ALU for register-register and register-immediate operations.
    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && funct7_5) ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = funct7_5 ? 32'($signed(rs1_val) >>> alu_b[4:0]) : (rs1_val >> alu_b[4:0]);
            3'b110: alu_res = rs1_val | alu_b;
            3'b111: alu_res = rs1_val & alu_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = (rs1_val == rs2_val);
            3'b001: branch_taken = (rs1_val != rs2_val);
            3'b100: branch_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: branch_taken = (rs1_val < rs2_val);
            3'b111: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Main decode: next PC, writeback value and store lanes; unrecognised encodings fall through as NOPs.
    always_comb begin
        next_pc    = pc + 32'd4;
        rd_we      = 1'b0;
        rd_data    = '0;
        store_strb = '0;
        store_data = '0;
        case (opcode)
            OPC_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OPC_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = pc + 32'd4;
                    next_pc = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000: begin rd_we = 1'b1; rd_data = {{24{load_byte[7]}}, load_byte}; end
                    3'b001: begin rd_we = 1'b1; rd_data = {{16{load_half[15]}}, load_half}; end
                    3'b010: begin rd_we = 1'b1; rd_data = mem_rdata; end
                    3'b100: begin rd_we = 1'b1; rd_data = {24'd0, load_byte}; end
                    3'b101: begin rd_we = 1'b1; rd_data = {16'd0, load_half}; end
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000: begin
                        store_strb = 4'b0001 << lane;
                        store_data = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        store_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
                        store_data = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        store_strb = 4'b1111;
                        store_data = rs2_val;
                    end
                    default: ;
                endcase
            end
            OPC_OPIMM, OPC_OP: begin
                rd_we   = 1'b1;
                rd_data = alu_res;
            end
            default: ;
        endcase
    end

    // Program counter; frozen while the debug hold is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (!hold) begin
            pc <= next_pc;
        end
    end
endmodule

// SoC top: core plus ROM and RAM decoded on address bits [31:28].
module tinyriscv_soc #(
    parameter int ROM_DEPTH = 4096,
    parameter int RAM_DEPTH = 4096
) (
    input logic clk,
    input logic rst,
    input logic uart_debug_pin
);
    logic [29:0] inst_word;
    logic [31:0] inst;
    logic [29:0] data_word;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [31:0] rom_rdata;
    logic [31:0] ram_rdata;
    logic [3:0]  region;
    logic [3:0]  rom_wstrb;
    logic [3:0]  ram_wstrb;

    assign region    = data_word[29:26];
    assign rom_wstrb = (region == 4'h0) ? wstrb : 4'b0000;
    assign ram_wstrb = (region == 4'h1) ? wstrb : 4'b0000;

    tinyriscv_core u_tinyriscv_2023211063 (
        .clk       (clk),
        .rst       (rst),
        .hold      (uart_debug_pin),
        .inst_word (inst_word),
        .inst      (inst),
        .mem_word  (data_word),
        .mem_wdata (wdata),
        .mem_wstrb (wstrb),
        .mem_rdata (rdata)
    );

    tinyriscv_rom #(.DEPTH(ROM_DEPTH)) u_rom (
        .clk       (clk),
        .inst_word (inst_word),
        .inst      (inst),
        .data_word (data_word),
        .wstrb     (rom_wstrb),
        .wdata     (wdata),
        .rdata     (rom_rdata)
    );

    tinyriscv_ram #(.DEPTH(RAM_DEPTH)) u_ram (
        .clk       (clk),
        .data_word (data_word),
        .wstrb     (ram_wstrb),
        .wdata     (wdata),
        .rdata     (ram_rdata)
    );

    // Load data mux; unmapped regions read as zero.
    always_comb begin
        rdata = '0;
        case (region)
            4'h0:    rdata = rom_rdata;
            4'h1:    rdata = ram_rdata;
            default: rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_tinyriscv_soc.sv
// tb_tinyriscv_soc: directed programs with hand-computed register results.
module tb_tinyriscv_soc;
    localparam int ROM_WORDS = 4096;
    localparam int FAIL_ADDR = 32'h200;

    logic clk;
    logic rst;
    logic uart_debug_pin;
    int   checks;
    int   errors;
    int   wp;

    tinyriscv_soc #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_debug_pin (uart_debug_pin)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] xr(input int n);
        return dut.u_tinyriscv_2023211063.u_regs_2023211063.regs[n];
    endfunction

    function automatic logic [31:0] cur_pc();
        return dut.u_tinyriscv_2023211063.pc;
    endfunction

    function automatic logic [31:0] f_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] a, b, c, d, e;
        a = imm; b = rs1; c = f3; d = rd; e = op;
        return {a[11:0], b[4:0], c[2:0], d[4:0], e[6:0]};
    endfunction

    function automatic logic [31:0] f_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] f_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] a, b, c, d;
        a = imm; b = rs2; c = rs1; d = f3;
        return {a[11:5], b[4:0], c[4:0], d[2:0], a[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] f_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] a, b, c, d;
        a = imm; b = rs2; c = rs1; d = f3;
        return {a[12], a[10:5], b[4:0], c[4:0], d[2:0], a[4:1], a[11], 7'h63};
    endfunction

    function automatic logic [31:0] f_u(input int imm20, input int rd, input int op);
        logic [31:0] a, b, c;
        a = imm20; b = rd; c = op;
        return {a[19:0], b[4:0], c[6:0]};
    endfunction

    function automatic logic [31:0] f_j(input int imm, input int rd);
        logic [31:0] a, b;
        a = imm; b = rd;
        return {a[20], a[10:1], a[11], a[19:12], b[4:0], 7'h6f};
    endfunction

    task automatic emit(input logic [31:0] w);
        dut.u_rom._rom[wp] = w;
        wp = wp + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the core in reset and fill the ROM with NOPs before a new program.
    task automatic begin_load();
        @(negedge clk);
        rst = 1'b0;
        uart_debug_pin = 1'b0;
        for (int i = 0; i < ROM_WORDS; i++) begin
            dut.u_rom._rom[i] = 32'h0000_0013;
        end
        wp = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_selfcheck(input bit bad);
        begin_load();
        emit(f_i(1, 0, 0, 3, 'h13));
        emit(f_i(-1, 0, 0, 10, 'h13));
        emit(f_i(1, 0, 0, 11, 'h13));
        emit(f_r(0, 11, 10, 2, 12));
        emit(f_i(1, 0, 0, 13, 'h13));
        emit(f_b(FAIL_ADDR - 4*wp, 13, 12, 1));
        emit(f_i(2, 0, 0, 3, 'h13));
        emit(f_r(0, 11, 10, 3, 12));
        emit(f_b(FAIL_ADDR - 4*wp, 0, 12, 1));
        emit(f_i(3, 0, 0, 3, 'h13));
        emit(f_i('h404, 10, 5, 12, 'h13));
        emit(f_b(FAIL_ADDR - 4*wp, 10, 12, 1));
        emit(f_i(4, 0, 0, 3, 'h13));
        emit(f_i(28, 10, 5, 12, 'h13));
        emit(f_i(bad ? 14 : 15, 0, 0, 13, 'h13));
        emit(f_b(FAIL_ADDR - 4*wp, 13, 12, 1));
        emit(f_i(5, 0, 0, 3, 'h13));
        emit(f_b(FAIL_ADDR - 4*wp, 10, 11, 4));
        emit(f_b(FAIL_ADDR - 4*wp, 10, 11, 7));
        emit(f_i(6, 0, 0, 3, 'h13));
        emit(f_r('h20, 11, 0, 0, 12));
        emit(f_b(FAIL_ADDR - 4*wp, 10, 12, 1));
        emit(f_i(1, 0, 0, 27, 'h13));
        emit(f_i(1, 0, 0, 26, 'h13));
        emit(f_j(0, 0));
        wp = FAIL_ADDR / 4;
        emit(f_i(1, 0, 0, 26, 'h13));
        emit(f_j(0, 0));
    endtask

    // Wait (bounded to 1 ms of simulated time) for the done flag, then check the verdict registers.
    task automatic wait_done_check(input string tag, input logic [31:0] exp27, input logic [31:0] exp3);
        int cyc;
        cyc = 0;
        while (xr(26) !== 32'd1 && cyc < 50000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (xr(26) !== 32'd1) begin
            errors++;
            $display("[TB] FAIL %s_done x26 got %h exp %h", tag, xr(26), 32'd1);
        end
        checks++;
        if (xr(27) !== exp27) begin
            errors++;
            $display("[TB] FAIL %s_pass x27 got %h exp %h", tag, xr(27), exp27);
        end
        checks++;
        if (xr(3) !== exp3) begin
            errors++;
            $display("[TB] FAIL %s_testnum x3 got %h exp %h", tag, xr(3), exp3);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cur_pc() !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_pc got %h exp %h", cur_pc(), 32'd0);
        end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (xr(i) !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_x%0d got %h exp %h", i, xr(i), 32'd0);
            end
        end
        step(2);
        checks++;
        if (cur_pc() !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_pc_held got %h exp %h", cur_pc(), 32'd0);
        end
    endtask

    task automatic test_alu();
        int          rn [9]  = '{1, 2, 3, 4, 6, 7, 8, 9, 10};
        logic [31:0] ev [9]  = '{32'd5, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFF9, 32'd0,
                                 32'hFFFF_FFFF, 32'h0000_00A0, 32'h0000_1020, 32'hFFFF_FFFA};
        begin_load();
        emit(f_i(5, 0, 0, 1, 'h13));
        emit(f_i(-7, 1, 0, 2, 'h13));
        emit(f_r(0, 2, 1, 0, 3));
        emit(f_i(9, 0, 0, 0, 'h13));
        emit(f_i('h305, 1, 1, 6, 'h73));
        emit(f_r('h20, 1, 2, 0, 4));
        emit(f_r('h20, 1, 2, 5, 7));
        emit(f_r(0, 1, 1, 1, 8));
        emit(f_u(1, 9, 'h17));
        emit(f_i(-1, 1, 4, 10, 'h13));
        emit(f_i(-1, 1, 3, 11, 'h13));
        release_reset();
        step(3);
        checks++;
        if (xr(1) !== 32'd5 || xr(2) !== 32'hFFFF_FFFE || xr(3) !== 32'd3) begin
            errors++;
            $display("[TB] FAIL alu_first3 got %h %h %h exp 00000005 fffffffe 00000003", xr(1), xr(2), xr(3));
        end
        step(8);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (xr(rn[i]) !== ev[i]) begin
                errors++;
                $display("[TB] FAIL alu_x%0d got %h exp %h", rn[i], xr(rn[i]), ev[i]);
            end
        end
        checks++;
        if (xr(11) !== 32'd1 || xr(0) !== 32'd0) begin
            errors++;
            $display("[TB] FAIL alu_sltiu_x0 got %h %h exp 00000001 00000000", xr(11), xr(0));
        end
        checks++;
        if (cur_pc() !== 32'h2C) begin
            errors++;
            $display("[TB] FAIL alu_pc got %h exp %h", cur_pc(), 32'h2C);
        end
    endtask

    task automatic test_load_store();
        int          rn [11] = '{5, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17};
        logic [31:0] ev [11] = '{32'h1000_0000, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8000,
                                 32'h0000_0080, 32'hFFFF_FFFE, 32'h0000_FFFE, 32'hFFFF_FFFE,
                                 32'h0080_FFFE, 32'h0000_0080, 32'h0000_0000};
        begin_load();
        emit(f_u('h10000, 5, 'h37));
        emit(f_i('h80, 0, 0, 6, 'h13));
        emit(f_s(0, 0, 5, 2));
        emit(f_s(1, 6, 5, 0));
        emit(f_i(1, 5, 0, 7, 'h03));
        emit(f_i(1, 5, 4, 8, 'h03));
        emit(f_i(0, 5, 2, 9, 'h03));
        emit(f_s(2, 6, 5, 1));
        emit(f_i(2, 5, 1, 10, 'h03));
        emit(f_i(-2, 0, 0, 11, 'h13));
        emit(f_s(0, 11, 5, 1));
        emit(f_i(0, 5, 5, 12, 'h03));
        emit(f_i(0, 5, 1, 13, 'h03));
        emit(f_i(0, 5, 2, 14, 'h03));
        emit(f_s('h400, 6, 0, 2));
        emit(f_i('h400, 0, 2, 15, 'h03));
        emit(f_u('h20000, 16, 'h37));
        emit(f_i(1, 0, 0, 17, 'h13));
        emit(f_i(0, 16, 2, 17, 'h03));
        release_reset();
        step(19);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (xr(rn[i]) !== ev[i]) begin
                errors++;
                $display("[TB] FAIL ldst_x%0d got %h exp %h", rn[i], xr(rn[i]), ev[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        begin_load();
        emit(f_i(1, 0, 0, 1, 'h13));
        emit(f_b(8, 0, 1, 1));
        emit(f_i(7, 0, 0, 2, 'h13));
        emit(f_i(3, 0, 0, 4, 'h13));
        emit(f_j(16, 1));
        emit(f_i(9, 0, 0, 5, 'h13));
        emit(f_j(16, 0));
        emit(32'h0000_0013);
        emit(f_i(4, 0, 0, 6, 'h13));
        emit(f_i(0, 1, 0, 0, 'h67));
        emit(f_i(1, 0, 0, 7, 'h13));
        release_reset();
        step(5);
        checks++;
        if (xr(1) !== 32'h14 || cur_pc() !== 32'h24) begin
            errors++;
            $display("[TB] FAIL jal_link got x1=%h pc=%h exp x1=00000014 pc=00000024", xr(1), cur_pc());
        end
        step(1);
        checks++;
        if (cur_pc() !== 32'h14) begin
            errors++;
            $display("[TB] FAIL jalr_target got %h exp %h", cur_pc(), 32'h14);
        end
        step(3);
        checks++;
        if (xr(2) !== 32'd0 || xr(4) !== 32'd3) begin
            errors++;
            $display("[TB] FAIL bne_skip got x2=%h x4=%h exp x2=00000000 x4=00000003", xr(2), xr(4));
        end
        checks++;
        if (xr(5) !== 32'd9 || xr(6) !== 32'd4 || xr(7) !== 32'd1 || cur_pc() !== 32'h2C) begin
            errors++;
            $display("[TB] FAIL jump_path got x5=%h x6=%h x7=%h pc=%h exp 9 4 1 2c", xr(5), xr(6), xr(7), cur_pc());
        end
    endtask

    task automatic test_selfcheck();
        load_selfcheck(1'b0);
        release_reset();
        wait_done_check("selfcheck", 32'd1, 32'd6);
        load_selfcheck(1'b1);
        release_reset();
        wait_done_check("failing_variant", 32'd0, 32'd4);
    endtask

    task automatic test_debug_hold();
        load_selfcheck(1'b0);
        release_reset();
        step(6);
        uart_debug_pin = 1'b1;
        step(10);
        checks++;
        if (cur_pc() !== 32'h18) begin
            errors++;
            $display("[TB] FAIL hold_pc got %h exp %h", cur_pc(), 32'h18);
        end
        checks++;
        if (xr(3) !== 32'd1 || xr(12) !== 32'd1 || xr(13) !== 32'd1) begin
            errors++;
            $display("[TB] FAIL hold_regs got x3=%h x12=%h x13=%h exp 1 1 1", xr(3), xr(12), xr(13));
        end
        uart_debug_pin = 1'b0;
        wait_done_check("after_hold", 32'd1, 32'd6);
    endtask

    task automatic test_reset_midrun();
        int bad_regs;
        load_selfcheck(1'b0);
        release_reset();
        step(10);
        #5 rst = 1'b0;
        #1;
        checks++;
        if (cur_pc() !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_pc got %h exp %h", cur_pc(), 32'd0);
        end
        bad_regs = 0;
        for (int i = 1; i < 32; i++) begin
            if (xr(i) !== 32'd0) bad_regs++;
        end
        checks++;
        if (bad_regs !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_regs nonzero count got %0d exp 0 (x3=%h)", bad_regs, xr(3));
        end
        release_reset();
        wait_done_check("rerun", 32'd1, 32'd6);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wp = 0;
        rst = 1'b1;
        uart_debug_pin = 1'b0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jump();
        test_selfcheck();
        test_debug_hold();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tinyriscv_soc.md
Name: tinyriscv_soc

Overview:
Minimal RV32I SoC top: a single-cycle RV32I core, an instruction/data ROM and a data RAM on a fixed address map. Executes a program preloaded into the ROM array and runs one instruction per clock after reset release. Self-checking test programs signal completion through architectural registers: x26=1 means done, x27=1 means pass, and x3 holds the test number.

Parameters:
ROM_DEPTH, 4096, ROM size in 32-bit words (byte base 0x0000_0000)
RAM_DEPTH, 4096, RAM size in 32-bit words (byte base 0x1000_0000)

Ports:
clk  input  1  system clock (rising edge)
rst  input  1  reset; asynchronous, active-low
uart_debug_pin  input  1  debug hold; 1 freezes the core (PC and all writes), 0 runs normally

Behaviour:
- Reset (rst=0, async): PC=0x0000_0000; x1..x31=0; RAM contents not reset; ROM contents untouched. Execution starts at the first rising clk edge with rst=1.
- Required hierarchy for bench access:
  - ROM instance u_rom, word array _rom[0:ROM_DEPTH-1], loaded by $readmemh.
  - Core instance u_tinyriscv_2023211063, containing register file u_regs_2023211063 with array regs[0:31] of 32 bits.
- Address map (byte addresses):
  - addr[31:28]=0x0 maps to ROM word addr[..:2].
  - addr[31:28]=0x1 maps to RAM.
  - Any other region: reads return 0, writes are ignored.
  - Word index wraps modulo depth.
- ROM: combinational read. Writable by stores with byte enables, so data sections in the image work.
- RAM: combinational read, synchronous byte-enabled write.
- Core, single-cycle:
  - Each rising edge (rst=1, uart_debug_pin=0): fetch _rom[PC[..:2]], decode, execute, write rd, update PC.
  - x0 always reads 0; writes to x0 are discarded.
  - Register file: two async read ports, one sync write port. A same-cycle read of rd returns the old value.
- Instructions:
  - LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic: 32-bit wraparound with no overflow trap. Shift amount is rs2[4:0] or shamt. SLT is signed, SLTU unsigned. Immediates are sign-extended per RV32I.
- JALR target = (rs1+imm) & ~1. Link value = PC+4. Branch and JAL targets are PC-relative.
- Loads:
  - LB/LBU select the byte lane by addr[1:0]; LH/LHU select the half by addr[1].
  - Sign or zero extension per opcode. LW ignores addr[1:0].
- Stores: SB writes byte lane addr[1:0]; SH writes half addr[1]; SW writes the full word. Other lanes are preserved.
- FENCE, ECALL, EBREAK, CSR ops and unknown opcodes execute as NOP (PC+4, no writes).
- Misaligned instruction targets: PC[1:0] is ignored for fetch; no exception.
- uart_debug_pin=1: PC, register file and memory writes are held; the core resumes on the next edge after it returns to 0.
- Reset asserted mid-program returns PC and registers to 0 immediately, without waiting for clk. Execution restarts from 0 after release.

Test Plan:
- ROM: addi x1,x0,5; addi x2,x1,-7; add x3,x1,x2 -> after 3 clocks x1=5, x2=0xFFFFFFFE, x3=3; x0 stays 0 after addi x0,x0,9.
- ROM: lui x5,0x10000; li x6,0x80; sb x6,1(x5); lb x7,1(x5); lbu x8,1(x5); lw x9,0(x5) -> x7=0xFFFFFF80, x8=0x80, x9=0x00008000.
- Branch/jump: bne taken skips one instruction; jal x1 from PC 0x10 -> x1=0x14; jalr x0,0(x1) returns to 0x14.
- Self-check program ending with li x27,1; li x26,1 -> x26==1 and x27==1 within 1 ms of simulated time at 50 MHz. A failing variant leaves x27=0 and x3 at the failing test number.
- Hold uart_debug_pin=1 for 10 clocks mid-run -> PC and registers unchanged; the program completes identically afterwards.
- Drop rst to 0 between clock edges mid-run -> PC=0 and x1..x31=0 immediately; rerun yields the same final results.
